// File: rtl/sar_scan_sequencer.sv
// Scan controller for the 3-bit SAR converter: walks the enabled mux channels,
// settles, runs one start/end handshake per channel and banks each result.
module sar_scan_sequencer #(
  parameter int NCH     = 4,
  parameter int DW      = 3,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 32,
  parameter int SELW    = $clog2(NCH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              continuous,
  input  logic [NCH-1:0]    chanMask,
  input  logic              nEndCnv,
  input  logic [DW-1:0]     dataIn,
  output logic              nStartCnv,
  output logic [SELW-1:0]   muxSel,
  output logic [NCH*DW-1:0] resultData,
  output logic [NCH-1:0]    resultValid,
  output logic              sampleStrobe,
  output logic [SELW-1:0]   sampleChan,
  output logic              busy,
  output logic              sweepDone,
  output logic              timeoutErr
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETTLE    = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_CAPTURE   = 3'd5;
  localparam logic [2:0] S_NEXT      = 3'd6;

  // One counter serves both the settle delay and the handshake timeout.
  localparam int             CNTMAX    = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int             CW        = $clog2(CNTMAX + 1);
  localparam logic [CW-1:0]  SETTLE_C  = CW'(SETTLE);
  localparam logic [CW-1:0]  TIMEOUT_C = CW'(TIMEOUT - 1);

  logic [2:0]      state;
  logic [NCH-1:0]  mask_q;
  logic [SELW-1:0] chan;
  logic [CW-1:0]   cnt;
  logic [SELW-1:0] first_chan;
  logic [SELW-1:0] nxt_chan;
  logic            nxt_found;

  // NOTE: every variable gets a default before the loops so no latch is inferred.
  always_comb begin
    first_chan = '0;
    nxt_chan   = '0;
    nxt_found  = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (chanMask[i]) first_chan = SELW'(i);
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(chan))) begin
        nxt_found = 1'b1;
        nxt_chan  = SELW'(i);
      end
    end
  end

  assign muxSel = chan;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the result bank is reset too, so software never reads stale data after reset.
      state        <= S_IDLE;
      mask_q       <= '0;
      chan         <= '0;
      cnt          <= '0;
      nStartCnv    <= 1'b1;
      resultData   <= '0;
      resultValid  <= '0;
      sampleStrobe <= 1'b0;
      sampleChan   <= '0;
      sweepDone    <= 1'b0;
      timeoutErr   <= 1'b0;
    end else begin
      nStartCnv    <= 1'b1;
      sampleStrobe <= 1'b0;
      sweepDone    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && (|chanMask)) begin
            mask_q     <= chanMask;
            timeoutErr <= 1'b0;
            chan       <= first_chan;
            cnt        <= '0;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_C) begin
            nStartCnv <= 1'b0;
            state     <= S_START;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // The handshake is tested first so it wins over a coincident timeout.
          if (nEndCnv) begin
            cnt   <= '0;
            state <= S_WAIT_DONE;
          end else if (cnt == TIMEOUT_C) begin
            timeoutErr <= 1'b1;
            state      <= S_NEXT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!nEndCnv) begin
            state <= S_CAPTURE;
          end else if (cnt == TIMEOUT_C) begin
            timeoutErr <= 1'b1;
            state      <= S_NEXT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_CAPTURE: begin
          resultData[int'(chan)*DW +: DW] <= dataIn;
          resultValid[chan]               <= 1'b1;
          sampleStrobe                    <= 1'b1;
          sampleChan                      <= chan;
          state                           <= S_NEXT;
        end
        S_NEXT: begin
          if (nxt_found) begin
            chan  <= nxt_chan;
            cnt   <= '0;
            state <= S_SETTLE;
          end else begin
            sweepDone <= 1'b1;
            if (continuous && enable && (|chanMask)) begin
              mask_q     <= chanMask;
              timeoutErr <= 1'b0;
              chan       <= first_chan;
              cnt        <= '0;
              state      <= S_SETTLE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sar_scan_sequencer.md
# sar_scan_sequencer

Multi-channel scan controller for the 3-bit SAR converter. It steps an analog input mux over the enabled channels and waits a settle time after each mux change. It then launches one conversion via the converter's active-low start/end handshake, captures the 3-bit result into a per-channel register, and moves to the next channel. It sits between the system registers and the SAR register block, so software sees a bank of always-fresh channel results instead of driving conversions by hand.

## Interface
- NCH, 4: number of mux channels (2..8); SELW = clog2(NCH)
- DW, 3: converter result width
- SETTLE, 2: idle cycles between mux change and start (0 allowed)
- TIMEOUT, 32: max cycles in any wait state before abort

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  run scanning; sampled only in IDLE
- continuous  in  1  1 = repeat sweeps while enable; 0 = one sweep then IDLE
- chanMask  in  NCH  channel enables, latched at sweep start
- nEndCnv  in  1  converter end-of-conversion, high while converting
- dataIn  in  DW  converter result bus
- nStartCnv  out  1  converter start, active-low one-cycle pulse
- muxSel  out  SELW  analog mux select
- resultData  out  NCH*DW  channel k in bits [k*DW +: DW]
- resultValid  out  NCH  sticky per-channel "has captured at least once"
- sampleStrobe  out  1  one-cycle pulse on each capture
- sampleChan  out  SELW  channel of the current/last capture
- busy  out  1  high in any state but IDLE
- sweepDone  out  1  one-cycle pulse after last enabled channel captured
- timeoutErr  out  1  sticky; set on timeout, cleared by reset or new sweep start

## Operation
- Reset values: nStartCnv=1, muxSel=0, resultData=0, resultValid=0, sampleStrobe=0, sampleChan=0, busy=0, sweepDone=0, timeoutErr=0, state IDLE.
- IDLE:
  - If enable=1 and chanMask!=0: latch the mask into maskQ, clear timeoutErr, set chan to the lowest set bit of maskQ, go SETTLE.
  - If enable=1 and chanMask=0: stay in IDLE. No pulse is emitted.
- SETTLE: muxSel=chan. Count SETTLE cycles, then go START. With SETTLE=0, pass through in one cycle.
- START: drive nStartCnv=0 for exactly this one cycle, then go WAIT_BUSY.
- WAIT_BUSY: wait for nEndCnv=1 (converter sampling). Then go WAIT_DONE.
- WAIT_DONE: wait for nEndCnv=0. Then go CAPTURE.
- CAPTURE:
  - Write dataIn into slot chan and set resultValid[chan].
  - Pulse sampleStrobe and set sampleChan=chan.
  - Go NEXT.
- NEXT: find the next set bit of maskQ above chan.
  - If found: chan = that bit, go SETTLE.
  - If none: pulse sweepDone. If continuous=1 and enable=1, restart from the lowest set bit of the newly latched chanMask (go IDLE if it is 0). Otherwise go IDLE.
- Timeout:
  - A cycle counter is cleared on entry to WAIT_BUSY and WAIT_DONE.
  - Reaching TIMEOUT cycles in either state sets timeoutErr and forces nStartCnv=1.
  - The channel's result is not written. Go NEXT so the sweep continues.
- enable dropping mid-sweep: the current sweep completes. enable is checked only at IDLE and at the end of NEXT.
- chanMask changes mid-sweep: ignored until the next latch.
- Channel indices outside NCH are never selected. Mask bits are only NCH wide.

## Timing
- Start pulse: nStartCnv is low exactly one cycle, SETTLE+1 cycles after muxSel changes.
- Converter response: the converter raises nEndCnv 2 cycles after seeing start low, and drops it about 11 cycles later.
- Capture latency: CAPTURE occurs one cycle after nEndCnv is seen low. resultData and sampleStrobe update on the following edge.
- Per-channel turnaround, with a nominal converter: SETTLE + 1 (START) + 2 + 11 + 1 (CAPTURE) + 1 (NEXT) cycles.
- Reset mid-operation:
  - Next edge returns every output to its reset value, including resultData, resultValid and timeoutErr.
  - nStartCnv is high from that edge.
- Simultaneous events:
  - Timeout and nEndCnv edge in the same cycle: the handshake wins, no timeout.
  - sweepDone and sampleStrobe are never high in the same cycle (NEXT follows CAPTURE).

## Test plan
- Single sweep, chanMask=4'b1111, continuous=0, converter model returns 3,5,0,7 for ch0..3 -> four sampleStrobes with sampleChan 0,1,2,3; resultData=12'b111_000_101_011; resultValid=4'hF; one sweepDone; busy falls after it.
- Sparse mask 4'b1010, SETTLE=2 -> muxSel visits only 1 then 3; nStartCnv low exactly 1 cycle, 3 cycles after each muxSel change; resultValid=4'b1010.
- Converter held with nEndCnv=0 on ch2, mask 4'b0111 -> timeoutErr set TIMEOUT cycles after start; ch2 slot unchanged; ch0/ch1 captured; sweepDone still pulses.
- Continuous mode, mask 4'b0011, enable dropped during ch0 conversion -> ch1 still converts, sweepDone pulses, then IDLE; no further nStartCnv pulse.
- reset asserted during WAIT_DONE -> next edge: nStartCnv=1, busy=0, resultValid=0, resultData=0; no capture when nEndCnv later falls.
- enable=1 with chanMask=0 -> stays IDLE; busy, nStartCnv and sweepDone never toggle over 100 cycles.
